// File: rtl/ex_mem_dmem.sv
// ----------------------------------------------------------------------------
// ex_mem_dmem
// EX/MEM pipeline register merged with the data-memory access controller.
// Captures the EX-stage bundle whenever the stage is not stalled, issues a
// req/ack data-memory access for loads/stores, stalls upstream while the
// access is outstanding and presents the result bundle to MEM/WB (bubbles
// while busy).
//
// Optional build macro: MEM_TIMEOUT_EN
//   Adds a 16-bit ACCESS watchdog; after TIMEOUT_CYCLES cycles without ack the
//   access is abandoned, MemData becomes 32'hDEADBEEF, RegWrite is cleared and
//   err_o pulses for the first DONE cycle. Without it err_o is tied low.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   flush_i                 capture a bubble instead of the EX bundle
//   MemRead_i .. RegAddr_i  EX-stage bundle
//   stall_o                 hold PC, IF/ID and ID/EX
//   mem_req_o .. mem_wdata_o  data-memory request side
//   mem_ack_i, mem_rdata_i  data-memory completion side
//   MemtoReg_o .. RegAddr_o bundle to MEM/WB
//   err_o                   access-timeout pulse
// ----------------------------------------------------------------------------
module ex_mem_dmem #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        flush_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic        MemtoReg_i,
   input  logic        RegWrite_i,
   input  logic [31:0] ALUResult_i,
   input  logic [31:0] WriteData_i,
   input  logic [4:0]  RegAddr_i,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        MemtoReg_o,
   output logic        RegWrite_o,
   output logic [31:0] ALUResult_o,
   output logic [31:0] MemData_o,
   output logic [4:0]  RegAddr_o,
   output logic        err_o
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned RAW  = 5;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // Reject a watchdog limit the 16-bit counter cannot represent.
   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("ex_mem_dmem: TIMEOUT_CYCLES must be in 1..65535");
   end

   logic [1:0]      state_q,      state_d;
   logic            mem_read_q,   mem_read_d;
   logic            mem_write_q,  mem_write_d;
   logic            mem_to_reg_q, mem_to_reg_d;
   logic            reg_write_q,  reg_write_d;
   logic [XLEN-1:0] alu_result_q, alu_result_d;
   logic [XLEN-1:0] write_data_q, write_data_d;
   logic [RAW-1:0]  reg_addr_q,   reg_addr_d;
   logic [XLEN-1:0] mem_data_q,   mem_data_d;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNTW    = 16;
   // Counter value seen in the last permitted ACCESS cycle (cleared on entry).
   localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT_CYCLES - 1);

   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
`endif

   logic in_access;
   logic cap_mem_op;

   assign in_access  = (state_q == ST_ACCESS);
   // Memory op after flush gating of the EX bundle being captured.
   assign cap_mem_op = ~flush_i & (MemRead_i | MemWrite_i);

   // State and bundle registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         reg_write_q  <= 1'b0;
         alu_result_q <= '0;
         write_data_q <= '0;
         reg_addr_q   <= '0;
         mem_data_q   <= '0;
`ifdef MEM_TIMEOUT_EN
         cnt_q        <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         reg_write_q  <= reg_write_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         reg_addr_q   <= reg_addr_d;
         mem_data_q   <= mem_data_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q        <= cnt_d;
         err_q        <= err_d;
`endif
      end
   end

   // Next-state and capture logic.
   always_comb begin
      state_d      = state_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_to_reg_d = mem_to_reg_q;
      reg_write_d  = reg_write_q;
      alu_result_d = alu_result_q;
      write_data_d = write_data_q;
      reg_addr_d   = reg_addr_q;
      mem_data_d   = mem_data_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d        = cnt_q;
      err_d        = 1'b0;
`endif

      case (state_q)
         ST_ACCESS: begin
            // Bundle frozen; flush_i has no effect while the access is open.
            if (mem_ack_i) begin
               if (mem_read_q) begin
                  mem_data_d = mem_rdata_i;
               end
               state_d = ST_DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               mem_data_d  = 32'hDEAD_BEEF;
               reg_write_d = 1'b0;
               err_d       = 1'b1;
               state_d     = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
`endif
         end
         default: begin
            // IDLE/DONE: MEM/WB takes the held bundle while the next op loads.
            mem_read_d   = MemRead_i  & ~flush_i;
            mem_write_d  = MemWrite_i & ~flush_i;
            mem_to_reg_d = MemtoReg_i & ~flush_i;
            reg_write_d  = RegWrite_i & ~flush_i;
            alu_result_d = ALUResult_i;
            write_data_d = WriteData_i;
            reg_addr_d   = RegAddr_i;
            state_d      = cap_mem_op ? ST_ACCESS : ST_IDLE;
`ifdef MEM_TIMEOUT_EN
            cnt_d        = '0;
`endif
         end
      endcase
   end

   // Memory port: a load wins when both MemRead and MemWrite are set.
   assign stall_o     = in_access;
   assign mem_req_o   = in_access;
   assign mem_we_o    = in_access & mem_write_q & ~mem_read_q;
   assign mem_addr_o  = {alu_result_q[XLEN-1:2], 2'b00};
   assign mem_wdata_o = write_data_q;

   // MEM/WB bundle; control bits become a bubble while the access is open.
   assign MemtoReg_o  = mem_to_reg_q & ~in_access;
   assign RegWrite_o  = reg_write_q  & ~in_access;
   assign ALUResult_o = alu_result_q;
   assign MemData_o   = mem_data_q;
   assign RegAddr_o   = reg_addr_q;

`ifdef MEM_TIMEOUT_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_dmem.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_dmem
// Scoreboard bench for ex_mem_dmem: each driven op pushes its expected MEM/WB
// bundle; the bundle is popped and compared when the stage releases it.
// ----------------------------------------------------------------------------
module tb_ex_mem_dmem;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        flush_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic        MemtoReg_i;
   logic        RegWrite_i;
   logic [31:0] ALUResult_i;
   logic [31:0] WriteData_i;
   logic [4:0]  RegAddr_i;
   logic        stall_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        MemtoReg_o;
   logic        RegWrite_o;
   logic [31:0] ALUResult_o;
   logic [31:0] MemData_o;
   logic [4:0]  RegAddr_o;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   ex_mem_dmem #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .flush_i     (flush_i),
      .MemRead_i   (MemRead_i),
      .MemWrite_i  (MemWrite_i),
      .MemtoReg_i  (MemtoReg_i),
      .RegWrite_i  (RegWrite_i),
      .ALUResult_i (ALUResult_i),
      .WriteData_i (WriteData_i),
      .RegAddr_i   (RegAddr_i),
      .stall_o     (stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i),
      .MemtoReg_o  (MemtoReg_o),
      .RegWrite_o  (RegWrite_o),
      .ALUResult_o (ALUResult_o),
      .MemData_o   (MemData_o),
      .RegAddr_o   (RegAddr_o),
      .err_o       (err_o)
   );

   typedef struct {
      logic        m2r;
      logic        rw;
      logic        chk_data;
      logic [31:0] alu;
      logic [4:0]  ra;
      logic        chk_mdata;
      logic [31:0] mdata;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] mdl;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one EX op and push the bundle MEM/WB should later see for it.
   task automatic drive_op(input logic fl, input logic rd, input logic wr,
                           input logic m2r, input logic rw, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [4:0] ra,
                           input logic [31:0] exp_mdata, input logic chk_mdata,
                           input logic exp_err);
      exp_t e;
      flush_i     = fl;
      MemRead_i   = rd;
      MemWrite_i  = wr;
      MemtoReg_i  = m2r;
      RegWrite_i  = rw;
      ALUResult_i = alu;
      WriteData_i = wd;
      RegAddr_i   = ra;
      e.m2r       = fl ? 1'b0 : m2r;
      e.rw        = (fl || exp_err) ? 1'b0 : rw;
      e.chk_data  = ~fl;
      e.alu       = alu;
      e.ra        = ra;
      e.chk_mdata = chk_mdata;
      e.mdata     = exp_mdata;
      e.err       = exp_err;
      sb_q.push_back(e);
   endtask

   task automatic nop_op(input logic [31:0] exp_mdata);
      drive_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, exp_mdata, 1'b1, 1'b0);
   endtask

   // Pop the oldest expected bundle and compare against the MEM/WB outputs.
   task automatic retire(input string tag);
      exp_t e;
      check({tag, "_pending"}, 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, "_stall"},    32'(stall_o),    32'd0);
         check({tag, "_req"},      32'(mem_req_o),  32'd0);
         check({tag, "_RegWrite"}, 32'(RegWrite_o), 32'(e.rw));
         check({tag, "_MemtoReg"}, 32'(MemtoReg_o), 32'(e.m2r));
         check({tag, "_err"},      32'(err_o),      32'(e.err));
         if (e.chk_data) begin
            check({tag, "_ALUResult"}, ALUResult_o,     e.alu);
            check({tag, "_RegAddr"},   32'(RegAddr_o),  32'(e.ra));
         end
         if (e.chk_mdata) begin
            check({tag, "_MemData"}, MemData_o, e.mdata);
         end
      end
   endtask

   // Service an access acked in its k-th ACCESS cycle; returns in the DONE cycle.
   task automatic access(input int k, input logic [31:0] rdata, input logic [31:0] addr,
                         input logic we, input logic [31:0] wdata, input logic fl_mid,
                         input string tag);
      for (int i = 1; i <= k; i++) begin
         @(negedge clk_i);
         check({tag, "_acc_stall"},    32'(stall_o),    32'd1);
         check({tag, "_acc_req"},      32'(mem_req_o),  32'd1);
         check({tag, "_acc_RegWrite"}, 32'(RegWrite_o), 32'd0);
         check({tag, "_acc_MemtoReg"}, 32'(MemtoReg_o), 32'd0);
         check({tag, "_acc_addr"},     mem_addr_o,      addr);
         check({tag, "_acc_we"},       32'(mem_we_o),   32'(we));
         if (we) begin
            check({tag, "_acc_wdata"}, mem_wdata_o, wdata);
         end
         if (fl_mid && i == 1) begin
            flush_i = 1'b1;
         end
         if (i == k) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = rdata;
         end
      end
      @(negedge clk_i);
      mem_ack_i   = 1'b0;
      mem_rdata_i = $urandom;
      flush_i     = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n_i     = 1'b0;
      flush_i     = 1'b0;
      MemRead_i   = 1'b0;
      MemWrite_i  = 1'b0;
      MemtoReg_i  = 1'b0;
      RegWrite_i  = 1'b0;
      ALUResult_i = 32'h0;
      WriteData_i = 32'h0;
      RegAddr_i   = 5'd0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'h0;
      mdl         = 32'h0;

      // Reset state.
      repeat (2) @(negedge clk_i);
      check("rst_stall",     32'(stall_o),    32'd0);
      check("rst_req",       32'(mem_req_o),  32'd0);
      check("rst_we",        32'(mem_we_o),   32'd0);
      check("rst_addr",      mem_addr_o,      32'd0);
      check("rst_wdata",     mem_wdata_o,     32'd0);
      check("rst_RegWrite",  32'(RegWrite_o), 32'd0);
      check("rst_MemtoReg",  32'(MemtoReg_o), 32'd0);
      check("rst_ALUResult", ALUResult_o,     32'd0);
      check("rst_MemData",   MemData_o,       32'd0);
      check("rst_RegAddr",   32'(RegAddr_o),  32'd0);
      check("rst_err",       32'(err_o),      32'd0);
      rst_n_i = 1'b1;

      // Plain ALU op: no stall.
      drive_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd5, mdl, 1'b0, 1'b0);
      @(negedge clk_i);
      retire("alu");

      // Load acked in the 3rd ACCESS cycle.
      mdl = 32'hCAFE_0001;
      drive_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0104, 32'h0, 5'd7, mdl, 1'b1, 1'b0);
      access(3, 32'hCAFE_0001, 32'h0000_0104, 1'b0, 32'h0, 1'b0, "ld");
      retire("ld");

      // Store acked in the 1st cycle; MemData keeps the prior load value.
      drive_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h1234_5678, 5'd0, mdl, 1'b1, 1'b0);
      access(1, 32'hFFFF_0000, 32'h0000_0020, 1'b1, 32'h1234_5678, 1'b0, "st");
      retire("st");

      // Op captured in the store's DONE cycle.
      drive_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0ABC, 32'h0, 5'd9, mdl, 1'b1, 1'b0);
      @(negedge clk_i);
      retire("alu2");

      // Flushed load: bubble, no request.
      drive_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd4, mdl, 1'b1, 1'b0);
      @(negedge clk_i);
      retire("flush_ld");

      // Flush asserted during ACCESS is ignored.
      mdl = 32'h0055_AA00;
      drive_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0, 5'd3, mdl, 1'b1, 1'b0);
      access(2, mdl, 32'h0000_0200, 1'b0, 32'h0, 1'b1, "ld_fl");
      retire("ld_fl");

      // Read+write treated as load, misaligned address truncated.
      mdl = 32'h1357_2468;
      drive_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0407, 32'hFFFF_FFFF, 5'd12, mdl, 1'b1, 1'b0);
      access(1, mdl, 32'h0000_0404, 1'b0, 32'h0, 1'b0, "ld_rw");
      retire("ld_rw");

      // Back-to-back load captured in DONE goes straight to ACCESS.
      mdl = 32'h89AB_CDEF;
      drive_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0, 5'd13, mdl, 1'b1, 1'b0);
      access(2, mdl, 32'h0000_0500, 1'b0, 32'h0, 1'b0, "ld_b2b");
      retire("ld_b2b");

      // Reset in the 2nd ACCESS cycle; a late ack is ignored.
      drive_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0600, 32'h0, 5'd14, mdl, 1'b1, 1'b0);
      @(negedge clk_i);
      check("rstacc_stall1", 32'(stall_o), 32'd1);
      @(negedge clk_i);
      check("rstacc_stall2", 32'(stall_o), 32'd1);
      #1 rst_n_i = 1'b0;
      #1;
      check("rstacc_async_stall", 32'(stall_o),   32'd0);
      check("rstacc_async_req",   32'(mem_req_o), 32'd0);
      sb_q.delete();
      mdl = 32'h0;
      @(negedge clk_i);
      rst_n_i     = 1'b1;
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hBAD0_BAD0;
      nop_op(mdl);
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      retire("post_rst");

`ifdef MEM_TIMEOUT_EN
      // Watchdog: no ack for TIMEOUT_CYCLES=4 ACCESS cycles.
      mdl = 32'hDEAD_BEEF;
      drive_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0700, 32'h0, 5'd15, mdl, 1'b1, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk_i);
         check("tmo_req", 32'(mem_req_o), 32'd1);
      end
      @(negedge clk_i);
      retire("tmo");
      nop_op(mdl);
      @(negedge clk_i);
      retire("tmo_after");
`endif

      nop_op(mdl);
      @(negedge clk_i);
      retire("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_mem_dmem.md
Name: ex_mem_dmem

Overview:
EX/MEM pipeline register combined with the data-memory access controller. It latches EX-stage results and drives a req/ack data-memory port. It stalls upstream while an access is outstanding and presents its result bundle directly to the MEM/WB register inputs. Bubbles go to MEM/WB while memory is busy.

Parameters:
TIMEOUT_CYCLES, 255, ACCESS-state cycles without ack before abort (used only with MEM_TIMEOUT_EN; legal range 1..65535).

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  capture a bubble instead of the EX bundle
MemRead_i  in  1  EX op is a load
MemWrite_i  in  1  EX op is a store
MemtoReg_i  in  1  EX writeback source select
RegWrite_i  in  1  EX register write enable
ALUResult_i  in  32  EX ALU result / effective address
WriteData_i  in  32  store data
RegAddr_i  in  5  destination register
stall_o  out  1  hold PC, IF/ID and ID/EX this cycle
mem_req_o  out  1  data-memory request
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  32  word address, {addr[31:2],2'b00}
mem_wdata_o  out  32  store data
mem_ack_i  in  1  memory completion, one-cycle pulse
mem_rdata_i  in  32  read data, valid with mem_ack_i
MemtoReg_o  out  1  to MEM/WB
RegWrite_o  out  1  to MEM/WB
ALUResult_o  out  32  to MEM/WB
MemData_o  out  32  to MEM/WB, load data
RegAddr_o  out  5  to MEM/WB
err_o  out  1  access-timeout pulse

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; all registers 0; every output 0, including stall_o and mem_req_o. Reset mid-access drops mem_req_o immediately; any late ack is ignored.
- States: IDLE (non-memory op or bubble held), ACCESS (request outstanding), DONE (memory result held).
- stall_o = (state==ACCESS), decoded from registered state only.
- Capture happens on any posedge with stall_o=0:
  - Latch all EX inputs.
  - If flush_i=1, latch MemRead, MemWrite, MemtoReg and RegWrite as 0; data fields are don't-care.
  - Next state is ACCESS if the captured MemRead|MemWrite=1, else IDLE.
- If MemRead_i and MemWrite_i are both 1, the op is treated as a load.
- ACCESS:
  - mem_req_o=1, and mem_we_o, mem_addr_o and mem_wdata_o are held stable until ack.
  - MemtoReg_o and RegWrite_o are forced to 0 (bubble into MEM/WB).
  - flush_i is ignored.
  - On mem_ack_i: latch mem_rdata_i into MemData (loads only; stores keep the old value), then go to DONE.
- DONE and IDLE:
  - Outputs present the latched bundle; mem_req_o=0.
  - The next op is captured at the same edge at which MEM/WB takes this result.
- Latency:
  - Non-memory op: 0 stall cycles.
  - Memory op acked in the k-th ACCESS cycle (k≥1): k stall cycles.
- mem_ack_i is ignored outside ACCESS.
- Back-to-back loads:
  - DONE captures the next load and goes to ACCESS.
  - No idle cycle is inserted.
- mem_addr_o drops addr[1:0]; misalignment is not detected.

Optional Feature:
MEM_TIMEOUT_EN:
- When defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If the counter reaches TIMEOUT_CYCLES with no ack, mem_req_o drops and the state goes to DONE.
  - MemData is set to 32'hDEADBEEF and RegWrite is forced to 0 for that op.
  - err_o pulses high for exactly the first DONE cycle.
  - An ack in the same cycle as the timeout wins (normal completion, no err_o).
- When undefined: no counter; ACCESS waits indefinitely; err_o is tied 0.

Test Plan:
- Reset then ALU op (RegWrite=1, ALUResult=32'h0000_0010, RegAddr=5) -> next cycle: RegWrite_o=1, ALUResult_o=32'h10, RegAddr_o=5, stall_o=0, mem_req_o=0.
- Load addr 32'h0000_0104, ack 3 cycles after req with rdata 32'hCAFE_0001 -> stall_o high exactly 3 cycles; mem_addr_o=32'h104, mem_we_o=0; RegWrite_o=0 while stalled; in DONE: MemData_o=32'hCAFE_0001, MemtoReg_o=1, RegWrite_o=1.
- Store addr 32'h20 with data 32'h1234_5678, ack in 1st cycle -> mem_we_o=1, mem_wdata_o=32'h1234_5678, one stall cycle; the following op is captured in the DONE cycle.
- flush_i=1 during a load capture -> no mem_req_o, RegWrite_o=0. flush_i=1 during ACCESS -> access completes normally.
- rst_n_i pulsed low in the 2nd ACCESS cycle -> mem_req_o and stall_o go 0 asynchronously; an ack one cycle later changes nothing.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, and no ack -> req high 4 cycles; then err_o=1 for one cycle, MemData_o=32'hDEADBEEF, RegWrite_o=0.
